rv_muldiv_unit: RTL and testbench



---
 rtl/rv_pkg.sv | 20 ++
 rtl/rv_muldiv_if.sv | 20 ++
 rtl/rv_muldiv_sign.sv | 13 +
 rtl/rv_muldiv_unit.sv | 119 +++++++++++
 tb/tb_rv_muldiv_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 codes and FSM states.
package rv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rv_muldiv_if.sv
// Request/response bundle between the control unit (master) and the multiply/divide unit (slave).
interface rv_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            op;
    logic            f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            is_mdu;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, f7, f3, a, b,
                    input  is_mdu, busy, done, result);
    modport slave  (input  start, op, f7, f3, a, b,
                    output is_mdu, busy, done, result);
endinterface

// File: rtl/rv_muldiv_sign.sv
// Conditional two's-complement negation: turns a signed operand into a magnitude, or
// re-applies the sign to a finished magnitude result.
module rv_muldiv_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply, restoring divide, one bit per
// cycle over magnitudes, with the sign fixed up in a single trailing cycle.
module rv_muldiv_unit import rv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    rv_muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3_q;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   m;
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   res_q;

    logic              is_div_in, sgn_a_in, sgn_b_in, na_in, nb_in;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   ma_in, mb_in, fast_res;
    logic [XLEN:0]     mul_sum, div_sh, div_tr;
    logic [2*XLEN-1:0] step_next, fix_in, fix_out;
    logic              fix_neg;
    logic [XLEN-1:0]   fix_res;

    assign bus.is_mdu = bus.op & bus.f7;

    // Operand signedness: MULHSU treats only rs1 as signed, the U variants neither.
    always_comb begin
        is_div_in = bus.f3[2];
        sgn_a_in  = is_div_in ? ~bus.f3[0] : (bus.f3[1:0] != 2'b11);
        sgn_b_in  = is_div_in ? ~bus.f3[0] : ~bus.f3[1];
        na_in     = sgn_a_in & bus.a[XLEN-1];
        nb_in     = sgn_b_in & bus.b[XLEN-1];
        div_zero  = is_div_in & (bus.b == '0);
        div_ovf   = is_div_in & ~bus.f3[0] & (bus.a == MOST_NEG) & (&bus.b);
        if (div_zero) fast_res = bus.f3[1] ? bus.a : '1;
        else          fast_res = bus.f3[1] ? '0 : bus.a;
    end

    rv_muldiv_sign #(.W(XLEN)) u_sign_a (.val(bus.a), .neg(na_in), .res(ma_in));
    rv_muldiv_sign #(.W(XLEN)) u_sign_b (.val(bus.b), .neg(nb_in), .res(mb_in));

    // p holds {acc_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
        div_sh  = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        div_tr  = div_sh - {1'b0, m};
        if (!f3_q[2])        step_next = {mul_sum, p[XLEN-1:1]};
        else if (!div_tr[XLEN]) step_next = {div_tr[XLEN-1:0], p[XLEN-2:0], 1'b1};
        else                 step_next = {div_sh[XLEN-1:0], p[XLEN-2:0], 1'b0};
    end

    // Remainder follows the dividend's sign; product and quotient follow the sign product.
    always_comb begin
        if (f3_q[2]) fix_in = {{XLEN{1'b0}}, (f3_q[1] ? p[2*XLEN-1:XLEN] : p[XLEN-1:0])};
        else         fix_in = p;
        fix_neg = (f3_q[2] & f3_q[1]) ? neg_a : (neg_a ^ neg_b);
        fix_res = (f3_q[2] || f3_q == F3_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
    end

    rv_muldiv_sign #(.W(2*XLEN)) u_sign_fix (.val(fix_in), .neg(fix_neg), .res(fix_out));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            m        <= '0;
            p        <= '0;
            res_q    <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: if (bus.start && bus.is_mdu) begin
                    f3_q     <= bus.f3;
                    neg_a    <= na_in;
                    neg_b    <= nb_in;
                    cnt      <= CNT_W'(XLEN-1);
                    bus.busy <= 1'b1;
                    if (div_zero || div_ovf) begin
                        res_q <= fast_res;
                        state <= S_DONE;
                    end else begin
                        m     <= is_div_in ? mb_in : ma_in;
                        p     <= {{XLEN{1'b0}}, (is_div_in ? ma_in : mb_in)};
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    p   <= step_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    res_q <= fix_res;
                    state <= S_DONE;
                end
                S_DONE: begin
                    bus.result <= res_q;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Randomised and directed checks of rv_muldiv_unit against an arithmetic reference model.
module tb_rv_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    bit          pend = 1'b0;
    int          acc_cyc, exp_done;
    logic [31:0] exp_res, last_res = '0;

    rv_muldiv_if #(.XLEN(XLEN)) bus ();
    rv_muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        pr = '0;
        case (f3)
            3'd0: begin pr = 64'(sa * sb); return pr[31:0]; end
            3'd1: begin pr = 64'(sa * sb); return pr[63:32]; end
            3'd2: begin pr = 64'(sa * ub); return pr[63:32]; end
            3'd3: begin pr = {32'b0, a} * {32'b0, b}; return pr[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == MOST_NEG && b == '1) return a;
                pr = 64'(sa / sb); return pr[31:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MOST_NEG && b == '1) return '0;
                pr = 64'(sa % sb); return pr[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == MOST_NEG && b == '1));
    endfunction

    // Single compare process: handshake every cycle, result on the done cycle.
    always @(negedge clk) begin
        n_chk++;
        if (pend) begin
            if (bus.busy !== (cyc < exp_done) || bus.done !== (cyc == exp_done)) begin
                n_fail++;
                $display("FAIL handshake cyc=%0d busy=%b done=%b expected busy=%b done=%b",
                         cyc - acc_cyc, bus.busy, bus.done, cyc < exp_done, cyc == exp_done);
            end
            if (cyc >= exp_done) begin
                n_chk++;
                if (bus.result !== exp_res) begin
                    n_fail++;
                    $display("FAIL result got=%h expected=%h", bus.result, exp_res);
                end
                last_res = exp_res;
                pend = 1'b0;
            end
        end else if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.f7 = 1'b1;
        bus.f3 = f3; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        exp_done = cyc + (is_fast(f3, a, b) ? 1 : XLEN + 2);
        exp_res  = exp;
        pend     = 1'b1;
        bus.start = 1'b0;
        bus.f3 = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    endtask

    task automatic pulse(input logic op, input logic f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.f7 = f7; bus.f3 = f3; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (pend && t < 200) begin @(negedge clk); t++; end
        if (pend) begin
            n_chk++; n_fail++;
            $display("FAIL timeout waited=%0d cycles expected done by %0d", t, exp_done - acc_cyc);
            pend = 1'b0;
        end
    endtask

    task automatic hold_check();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        n_chk++;
        if (bus.result !== last_res) begin
            n_fail++;
            $display("FAIL hold got=%h expected=%h", bus.result, last_res);
        end
    endtask

    logic [2:0]  d_f3 [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_r  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0};

    function automatic logic [31:0] pick();
        logic [31:0] sp [4] = '{32'd0, 32'hFFFF_FFFF, MOST_NEG, 32'd1};
        case ($urandom_range(0, 3))
            0: return sp[$urandom_range(0, 3)];
            1: return $urandom_range(0, 1) ? 32'($urandom_range(0, 20)) : -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, mr;
        logic [2:0]  rf;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.f7 = 1'b0; bus.f3 = '0; bus.a = '0; bus.b = '0;
        @(negedge clk);
        n_chk++;
        if (bus.result !== '0) begin
            n_fail++; $display("FAIL reset_result got=%h expected=0", bus.result);
        end
        for (int i = 0; i < 4; i++) begin
            bus.op = i[0]; bus.f7 = i[1]; #1;
            n_chk++;
            if (bus.is_mdu !== (i[0] & i[1])) begin
                n_fail++; $display("FAIL is_mdu got=%b expected=%b", bus.is_mdu, i[0] & i[1]);
            end
        end
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            mr = model(d_f3[i], d_a[i], d_b[i]);
            n_chk++;
            if (mr !== d_r[i]) begin
                n_fail++; $display("FAIL model_pin idx=%0d got=%h expected=%h", i, mr, d_r[i]);
            end
            issue(d_f3[i], d_a[i], d_b[i], d_r[i]);
            wait_done();
            hold_check();
        end

        // Requests that must be ignored: not an M-op, and starts while busy or in DONE.
        pulse(1'b1, 1'b0, 3'd0, 32'd3, 32'd4);
        pulse(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        issue(3'd0, 32'd1234, 32'd5678, 32'd7006652);
        while (cyc < acc_cyc + 5) @(negedge clk);
        pulse(1'b1, 1'b1, 3'd5, 32'd99, 32'd3);
        while (cyc < exp_done - 2) @(negedge clk);
        pulse(1'b1, 1'b1, 3'd4, 32'd50, 32'd5);
        wait_done();
        hold_check();

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom); ra = pick(); rb = pick();
            issue(rf, ra, rb, model(rf, ra, rb));
            wait_done();
            hold_check();
        end

        // Asynchronous reset part-way through CALC.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
        while (cyc < acc_cyc + 10) @(negedge clk);
        @(posedge clk); #2;
        pend = 1'b0;
        reset = 1'b1;
        #1;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
            n_fail++;
            $display("FAIL async_reset busy=%b done=%b result=%h expected 0 0 0",
                     bus.busy, bus.done, bus.result);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        last_res = '0;
        issue(3'd0, 32'd3, 32'd5, 32'd15);
        wait_done();
        hold_check();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
